multi_cycle_ctrl: RTL and testbench

- Multi-cycle sequencing controller for the MIPS-subset CPU datapath (register file, ALU, data memory, PC unit).
- Decodes Inst_code from the instruction register and steps IF/ID/EX/MEM/WB, driving the ALU and register-file controls plus the PC, IR and memory write strobes.
- Replaces single-cycle decode, so each instruction takes 2 to 5 cycles of clk.

---
 rtl/multi_cycle_ctrl_if.sv | 31 +++
 rtl/multi_cycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS-subset datapath (slave).
// Names follow the datapath's existing control-signal names.
interface multi_cycle_ctrl_if;
    logic [31:0] Inst_code;
    logic        ZF;
    logic        OF;
    logic        PC_Write;
    logic [1:0]  PC_s;
    logic        IR_Write;
    logic        Write_Reg;
    logic        Mem_Write;
    logic [2:0]  ALU_OP;
    logic [1:0]  w_r_s;
    logic [1:0]  wr_data_s;
    logic        imm_s;
    logic        rt_imm_s;
    logic [2:0]  state;
    logic        ill_inst;

    modport master (
        input  Inst_code, ZF, OF,
        output PC_Write, PC_s, IR_Write, Write_Reg, Mem_Write, ALU_OP,
               w_r_s, wr_data_s, imm_s, rt_imm_s, state, ill_inst
    );

    modport slave (
        output Inst_code, ZF, OF,
        input  PC_Write, PC_s, IR_Write, Write_Reg, Mem_Write, ALU_OP,
               w_r_s, wr_data_s, imm_s, rt_imm_s, state, ill_inst
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: 2-5 cycles per instruction, outputs decoded from state + Inst_code.
// No backpressure; branch PC_Write is a same-cycle (Mealy) decision on ZF, strobes drop at once on reset.
module multi_cycle_ctrl #(
    parameter int PC_INC = 4
) (
    input  logic               clk,
    input  logic               rst,
    multi_cycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b010,
        S_EX   = 3'b011,
        S_MEM  = 3'b100,
        S_WB   = 3'b101
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_XOR = 3'b010, ALU_NOR = 3'b011,
                           ALU_ADD = 3'b100, ALU_SUB = 3'b101, ALU_SLT = 3'b110, ALU_SLL = 3'b111;

    state_t     state_q, state_d;
    logic       of_q, of_d;
    logic       ill_q, ill_d;

    logic [5:0] opcode, funct;
    logic       is_j, is_jal, is_jr, is_r_alu, is_i_alu, is_lw, is_sw, is_beq, is_bne;
    logic       ovf_chk, sext, legal;
    logic [2:0] alu_sel;
    logic       unused_ok;

    assign opcode    = bus.Inst_code[31:26];
    assign funct     = bus.Inst_code[5:0];
    // PC_INC is informational only: the datapath owns the PC+4 adder.
    assign unused_ok = ^{bus.Inst_code[25:6], 32'(PC_INC)};

    always_comb begin
        is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_r_alu = 1'b0; is_i_alu = 1'b0;
        is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        ovf_chk = 1'b0; sext = 1'b0; alu_sel = ALU_AND;
        case (opcode)
            6'b000000: begin
                is_r_alu = 1'b1;
                case (funct)
                    6'b100000: begin alu_sel = ALU_ADD; ovf_chk = 1'b1; end
                    6'b100010: begin alu_sel = ALU_SUB; ovf_chk = 1'b1; end
                    6'b100100: alu_sel = ALU_AND;
                    6'b100101: alu_sel = ALU_OR;
                    6'b100110: alu_sel = ALU_XOR;
                    6'b100111: alu_sel = ALU_NOR;
                    6'b101010: alu_sel = ALU_SLT;
                    6'b000000: alu_sel = ALU_SLL;
                    6'b001000: begin is_jr = 1'b1; is_r_alu = 1'b0; end
                    default:   is_r_alu = 1'b0;
                endcase
            end
            6'b000010: is_j   = 1'b1;
            6'b000011: is_jal = 1'b1;
            6'b001000: begin is_i_alu = 1'b1; alu_sel = ALU_ADD; sext = 1'b1; ovf_chk = 1'b1; end
            6'b001010: begin is_i_alu = 1'b1; alu_sel = ALU_SLT; sext = 1'b1; end
            6'b001100: begin is_i_alu = 1'b1; alu_sel = ALU_AND; end
            6'b001101: begin is_i_alu = 1'b1; alu_sel = ALU_OR;  end
            6'b001110: begin is_i_alu = 1'b1; alu_sel = ALU_XOR; end
            6'b100011: begin is_lw  = 1'b1; alu_sel = ALU_ADD; sext = 1'b1; end
            6'b101011: begin is_sw  = 1'b1; alu_sel = ALU_ADD; sext = 1'b1; end
            6'b000100: begin is_beq = 1'b1; alu_sel = ALU_SUB; sext = 1'b1; end
            6'b000101: begin is_bne = 1'b1; alu_sel = ALU_SUB; sext = 1'b1; end
            default: ;
        endcase
    end

    assign legal = is_r_alu | is_i_alu | is_lw | is_sw | is_beq | is_bne;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            of_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            of_q    <= of_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        of_d          = of_q;
        ill_d         = ill_q;
        bus.PC_Write  = 1'b0;
        bus.PC_s      = 2'b00;
        bus.IR_Write  = 1'b0;
        bus.Write_Reg = 1'b0;
        bus.Mem_Write = 1'b0;
        bus.ALU_OP    = 3'b000;
        bus.w_r_s     = 2'b00;
        bus.wr_data_s = 2'b00;
        bus.imm_s     = 1'b0;
        bus.rt_imm_s  = 1'b0;

        // ALU selects stay put from EX through WB so the datapath sees stable operands.
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            bus.ALU_OP   = alu_sel;
            bus.imm_s    = sext;
            bus.rt_imm_s = is_i_alu | is_lw | is_sw;
        end

        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                bus.IR_Write = 1'b1;
                bus.PC_Write = 1'b1;
                state_d      = S_ID;
            end
            S_ID: begin
                state_d = S_IF;
                if (is_j || is_jal) begin
                    bus.PC_Write = 1'b1;
                    bus.PC_s     = 2'b11;
                    if (is_jal) begin
                        bus.Write_Reg = 1'b1;
                        bus.w_r_s     = 2'b10;
                        bus.wr_data_s = 2'b10;
                    end
                end else if (is_jr) begin
                    bus.PC_Write = 1'b1;
                    bus.PC_s     = 2'b01;
                end else if (legal) begin
                    state_d = S_EX;
                end else begin
                    ill_d = 1'b1;
                end
            end
            S_EX: begin
                of_d = bus.OF;
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq || is_bne) begin
                    bus.PC_Write = (is_beq & bus.ZF) | (is_bne & ~bus.ZF);
                    bus.PC_s     = 2'b10;
                    state_d      = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.Mem_Write = is_sw;
                state_d       = is_sw ? S_IF : S_WB;
            end
            S_WB: begin
                // Signed overflow on add/sub/addi squashes the write instead of trapping.
                bus.Write_Reg = ~(ovf_chk & of_q);
                bus.w_r_s     = is_r_alu ? 2'b00 : 2'b01;
                bus.wr_data_s = is_lw ? 2'b01 : 2'b00;
                state_d       = S_IF;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state    = state_q;
    assign bus.ill_inst = ill_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: instruction-level vector table, reset corner sequences,
// and random instruction streams checked per cycle against a table-based reference model.
module tb_multi_cycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();
    multi_cycle_ctrl #(.PC_INC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef enum int {K_ILL, K_J, K_JAL, K_JR, K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE} kind_t;
    typedef struct { kind_t k; logic [2:0] alu; logic sx; logic ov; } info_t;
    typedef struct packed {
        logic pcw; logic [1:0] pcs; logic irw; logic wreg; logic memw; logic [2:0] alu;
        logic [1:0] wrs; logic [1:0] wds; logic imms; logic rtis; logic [2:0] st;
    } out_t;
    typedef struct {
        string nm; logic [31:0] ins; logic zf; logic ov; int cyc; logic [2:0] alu;
        logic wr; logic mw; logic pcw2; logic [1:0] pcs2; logic ill;
    } vec_t;

    info_t fn_tab [bit [5:0]];
    info_t op_tab [bit [5:0]];
    logic [5:0] fn_list [9]  = '{6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
    logic [5:0] op_list [11] = '{6'h02, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05};

    function automatic info_t classify(input logic [31:0] ins);
        info_t r;
        r = '{K_ILL, 3'b000, 1'b0, 1'b0};
        if (ins[31:26] == 6'd0) begin
            if (fn_tab.exists(ins[5:0])) r = fn_tab[ins[5:0]];
        end else if (op_tab.exists(ins[31:26])) begin
            r = op_tab[ins[31:26]];
        end
        return r;
    endfunction

    function automatic int ncyc(input kind_t k);
        case (k)
            K_BEQ, K_BNE:   return 3;
            K_RALU, K_IALU, K_SW: return 4;
            K_LW:           return 5;
            default:        return 2;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction, with a care mask for don't-care selects.
    function automatic void model(input info_t inf, input int k, input logic zf, input logic ofr,
                                  output out_t e, output out_t m);
        int ph;  // 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB
        e = '0; m = '0;
        m.pcw = 1'b1; m.irw = 1'b1; m.wreg = 1'b1; m.memw = 1'b1; m.st = 3'b111;
        if (k < 3) ph = k;
        else if (k == 3 && (inf.k == K_LW || inf.k == K_SW)) ph = 3;
        else ph = 4;
        e.st = 3'(ph + 1);
        if (ph == 0) begin
            e.irw = 1'b1; e.pcw = 1'b1; m.pcs = 2'b11;
        end else if (ph == 1) begin
            if (inf.k == K_J || inf.k == K_JAL) begin e.pcw = 1'b1; e.pcs = 2'b11; end
            if (inf.k == K_JR) begin e.pcw = 1'b1; e.pcs = 2'b01; end
            if (inf.k == K_JAL) begin
                e.wreg = 1'b1; e.wrs = 2'b10; e.wds = 2'b10; m.wrs = 2'b11; m.wds = 2'b11;
            end
            if (e.pcw) m.pcs = 2'b11;
        end else begin
            e.alu  = inf.alu; m.alu = 3'b111; m.rtis = 1'b1;
            e.rtis = !(inf.k == K_RALU || inf.k == K_BEQ || inf.k == K_BNE);
            e.imms = inf.sx;  m.imms = (inf.k != K_RALU);
            if (ph == 2 && (inf.k == K_BEQ || inf.k == K_BNE)) begin
                e.pcw = (inf.k == K_BEQ) ? zf : !zf;
                e.pcs = 2'b10;
                m.pcs = e.pcw ? 2'b11 : 2'b00;
            end
            if (ph == 3 && inf.k == K_SW) e.memw = 1'b1;
            if (ph == 4) begin
                e.wreg = !(inf.ov && ofr);
                e.wrs  = (inf.k == K_RALU) ? 2'b00 : 2'b01;
                e.wds  = (inf.k == K_LW) ? 2'b01 : 2'b00;
                if (e.wreg) begin m.wrs = 2'b11; m.wds = 2'b11; end
            end
        end
    endfunction

    function automatic out_t snap();
        out_t o;
        o.pcw = bus.PC_Write; o.pcs = bus.PC_s; o.irw = bus.IR_Write; o.wreg = bus.Write_Reg;
        o.memw = bus.Mem_Write; o.alu = bus.ALU_OP; o.wrs = bus.w_r_s; o.wds = bus.wr_data_s;
        o.imms = bus.imm_s; o.rtis = bus.rt_imm_s; o.st = bus.state;
        return o;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        int s;
        r = $urandom;
        s = $urandom_range(0, 9);
        if (s >= 1 && s < 4) begin
            r[31:26] = 6'd0;
            r[5:0]   = fn_list[$urandom_range(0, 8)];
        end else if (s >= 4) begin
            r[31:26] = op_list[$urandom_range(0, 10)];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic go_to_if();
        int n = 0;
        while (bus.state !== 3'd1 && n < 8) begin tick(); n++; end
        chk("reach IF", 32'(bus.state), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int c = 0;
        logic [2:0] alu_ex = '0;
        logic wr_any = 1'b0, mw_any = 1'b0, pcw2 = 1'b0;
        logic [1:0] pcs2 = '0;
        do begin
            bus.Inst_code = v.ins;
            bus.ZF = (c == 2) ? v.zf : !v.zf;
            bus.OF = (c == 2) ? v.ov : !v.ov;
            #1;
            if (c == 2) alu_ex = bus.ALU_OP;
            wr_any |= bus.Write_Reg;
            mw_any |= bus.Mem_Write;
            if (c > 0 && bus.PC_Write) begin pcw2 = 1'b1; pcs2 = bus.PC_s; end
            tick();
            c++;
        end while (bus.state !== 3'd1 && c < 10);
        chk({v.nm, " cycles"}, 32'(c), 32'(v.cyc));
        if (v.cyc > 2) chk({v.nm, " alu_op"}, 32'(alu_ex), 32'(v.alu));
        chk({v.nm, " write_reg"}, 32'(wr_any), 32'(v.wr));
        chk({v.nm, " mem_write"}, 32'(mw_any), 32'(v.mw));
        chk({v.nm, " pc_write"}, 32'(pcw2), 32'(v.pcw2));
        if (v.pcw2) chk({v.nm, " pc_s"}, 32'(pcs2), 32'(v.pcs2));
        chk({v.nm, " ill_inst"}, 32'(bus.ill_inst), 32'(v.ill));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic ill_m, of_m;

        fn_tab[6'h20] = '{K_RALU, 3'b100, 1'b0, 1'b1};
        fn_tab[6'h22] = '{K_RALU, 3'b101, 1'b0, 1'b1};
        fn_tab[6'h24] = '{K_RALU, 3'b000, 1'b0, 1'b0};
        fn_tab[6'h25] = '{K_RALU, 3'b001, 1'b0, 1'b0};
        fn_tab[6'h26] = '{K_RALU, 3'b010, 1'b0, 1'b0};
        fn_tab[6'h27] = '{K_RALU, 3'b011, 1'b0, 1'b0};
        fn_tab[6'h2A] = '{K_RALU, 3'b110, 1'b0, 1'b0};
        fn_tab[6'h00] = '{K_RALU, 3'b111, 1'b0, 1'b0};
        fn_tab[6'h08] = '{K_JR,   3'b000, 1'b0, 1'b0};
        op_tab[6'h02] = '{K_J,    3'b000, 1'b0, 1'b0};
        op_tab[6'h03] = '{K_JAL,  3'b000, 1'b0, 1'b0};
        op_tab[6'h08] = '{K_IALU, 3'b100, 1'b1, 1'b1};
        op_tab[6'h0A] = '{K_IALU, 3'b110, 1'b1, 1'b0};
        op_tab[6'h0C] = '{K_IALU, 3'b000, 1'b0, 1'b0};
        op_tab[6'h0D] = '{K_IALU, 3'b001, 1'b0, 1'b0};
        op_tab[6'h0E] = '{K_IALU, 3'b010, 1'b0, 1'b0};
        op_tab[6'h23] = '{K_LW,   3'b100, 1'b1, 1'b0};
        op_tab[6'h2B] = '{K_SW,   3'b100, 1'b1, 1'b0};
        op_tab[6'h04] = '{K_BEQ,  3'b101, 1'b1, 1'b0};
        op_tab[6'h05] = '{K_BNE,  3'b101, 1'b1, 1'b0};

        //                 name        inst           zf    ov    cyc alu     wr    mw    pcw2  pcs2   ill
        vecs.push_back('{"add",      32'h00221820, 1'b0, 1'b0, 4, 3'b100, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"add_ov",   32'h00221820, 1'b0, 1'b1, 4, 3'b100, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"sub_ov",   32'h00221822, 1'b0, 1'b1, 4, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"sll_ov",   32'h00021080, 1'b0, 1'b1, 4, 3'b111, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"nor",      32'h00221827, 1'b0, 1'b0, 4, 3'b011, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"addi_ov",  32'h20220005, 1'b0, 1'b1, 4, 3'b100, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"slti_ov",  32'h2822FFFF, 1'b0, 1'b1, 4, 3'b110, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"andi",     32'h30220005, 1'b0, 1'b0, 4, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"ori",      32'h34220005, 1'b0, 1'b0, 4, 3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"xori_ov",  32'h38220005, 1'b0, 1'b1, 4, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"lw",       32'h8C410004, 1'b0, 1'b0, 5, 3'b100, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"sw",       32'hAC410004, 1'b0, 1'b0, 4, 3'b100, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"beq_take", 32'h10220003, 1'b1, 1'b0, 3, 3'b101, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0});
        vecs.push_back('{"beq_not",  32'h10220003, 1'b0, 1'b0, 3, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"bne_take", 32'h14220003, 1'b0, 1'b0, 3, 3'b101, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0});
        vecs.push_back('{"bne_not",  32'h14220003, 1'b1, 1'b0, 3, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{"j",        32'h08000010, 1'b0, 1'b0, 2, 3'b000, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0});
        vecs.push_back('{"jal",      32'h0C000010, 1'b0, 1'b0, 2, 3'b000, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0});
        vecs.push_back('{"jr",       32'h03E00008, 1'b0, 1'b0, 2, 3'b000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0});
        vecs.push_back('{"addu_ill", 32'h00221821, 1'b0, 1'b0, 2, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{"op3f_ill", 32'hFC000000, 1'b0, 1'b0, 2, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1});

        // Reset held: nothing may strobe and every select is zero.
        rst = 1'b0; bus.Inst_code = 32'h00221820; bus.ZF = 1'b1; bus.OF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("reset strobes", {28'd0, bus.PC_Write, bus.IR_Write, bus.Write_Reg, bus.Mem_Write}, 32'd0);
            chk("reset selects", {19'd0, bus.PC_s, bus.ALU_OP, bus.w_r_s, bus.wr_data_s, bus.imm_s, bus.rt_imm_s}, 32'd0);
            chk("reset state", 32'(bus.state), 32'd0);
            chk("reset ill", 32'(bus.ill_inst), 32'd0);
        end
        rst = 1'b1; #1;
        chk("idle state", 32'(bus.state), 32'd0);
        chk("idle strobes", {28'd0, bus.PC_Write, bus.IR_Write, bus.Write_Reg, bus.Mem_Write}, 32'd0);
        tick();
        chk("first IF state", 32'(bus.state), 32'd1);
        chk("first IF irw/pcw/pcs", {28'd0, bus.IR_Write, bus.PC_Write, bus.PC_s}, 32'b1100);
        tick();
        chk("first ID state", 32'(bus.state), 32'd2);
        chk("add ID strobes", {28'd0, bus.PC_Write, bus.IR_Write, bus.Write_Reg, bus.Mem_Write}, 32'd0);
        go_to_if();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset landing in the MEM cycle of a store must kill Mem_Write asynchronously.
        chk("ill sticky before reset", 32'(bus.ill_inst), 32'd1);
        bus.Inst_code = 32'hAC410004; bus.ZF = 1'b0; bus.OF = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("sw pre-MEM mem_write", 32'(bus.Mem_Write), 32'd0);
            tick();
        end
        chk("sw MEM state", 32'(bus.state), 32'd4);
        chk("sw MEM mem_write", 32'(bus.Mem_Write), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid-MEM reset mem_write", 32'(bus.Mem_Write), 32'd0);
        chk("mid-MEM reset state", 32'(bus.state), 32'd0);
        chk("mid-MEM reset ill", 32'(bus.ill_inst), 32'd0);
        tick();
        rst = 1'b1;
        go_to_if();

        ill_m = 1'b0;
        of_m  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            info_t inf;
            int n;
            if (i == 150) begin
                rst = 1'b0; #1;
                chk("rand reset state", 32'(bus.state), 32'd0);
                tick();
                rst = 1'b1;
                go_to_if();
                ill_m = 1'b0;
            end
            ins = gen_inst();
            inf = classify(ins);
            n   = ncyc(inf.k);
            for (int k = 0; k < n; k++) begin
                logic zf, ov;
                out_t e, m;
                zf = 1'($urandom_range(0, 1));
                ov = 1'($urandom_range(0, 1));
                bus.Inst_code = (k == 0) ? 32'($urandom) : ins;
                bus.ZF = zf;
                bus.OF = ov;
                #1;
                model(inf, k, zf, of_m, e, m);
                chk($sformatf("rand i%0d k%0d ins %h outputs", i, k, ins), 32'(snap() & m), 32'(e & m));
                chk($sformatf("rand i%0d k%0d ill_inst", i, k), 32'(bus.ill_inst), 32'(ill_m));
                if (k == 2) of_m = ov;
                if (k == 1 && inf.k == K_ILL) ill_m = 1'b1;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
